// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// default reset/handler PCs, default exception-code width and the
// default-width payload layout.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main entry only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;
    localparam int          DEFAULT_EXC_W      = 5;

    // Payload as seen with the default widths (32-bit PC and instruction).
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              instr;
        logic [DEFAULT_EXC_W-1:0] exccode;
        logic                     bd;
    } pipe_payload_t;

    // A stage can take a new entry whenever the skid slot is free.
    function automatic logic state_accepts(input state_t s);
        return (s != SKID);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at
// all-ones, cleared only by the asynchronous active-low reset.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry
// skid buffer so that in_ready is a flop output. A synchronous req flushes
// the stage and presents HANDLER_PC as a bubble.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is
// defined; otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              INSTR_W    = 32,
    parameter int              EXC_W      = DEFAULT_EXC_W,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC),
    parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(DEFAULT_HANDLER_PC),
    parameter int              CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [EXC_W-1:0]   in_exccode,
    input  logic               in_bd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [EXC_W-1:0]   out_exccode,
    output logic               out_bd,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Payload at this instance's widths.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [EXC_W-1:0]   exccode;
        logic               bd;
    } payload_t;

    // A nop bubble that keeps a given PC visible.
    function automatic payload_t bubble(input logic [PC_W-1:0] pc);
        payload_t p;
        p.pc      = pc;
        p.instr   = '0;
        p.exccode = '0;
        p.bd      = 1'b0;
        return p;
    endfunction

    state_t   state_q;
    state_t   state_d;
    payload_t main_q;
    payload_t main_d;
    payload_t skid_q;
    payload_t skid_d;
    logic     in_ready_q;
    logic     in_ready_d;

    payload_t in_payload;
    logic     in_accept;

    assign in_payload.pc      = in_pc;
    assign in_payload.instr   = in_instr;
    assign in_payload.exccode = in_exccode;
    assign in_payload.bd      = in_bd;

    // An upstream transfer only happens when the registered ready is high.
    assign in_accept = in_valid & in_ready_q;

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (req) begin
            // Any downstream handshake this cycle consumes main; skid and
            // the incoming entry are discarded.
            state_d = EMPTY;
            main_d  = bubble(HANDLER_PC);
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_accept) begin
                        state_d = FULL;
                        main_d  = in_payload;
                    end
                end
                FULL: begin
                    if (in_accept && out_ready) begin
                        main_d = in_payload;
                    end else if (in_accept) begin
                        state_d = SKID;
                        skid_d  = in_payload;
                    end else if (out_ready) begin
                        // Draining: show a nop but keep the last PC.
                        state_d = EMPTY;
                        main_d  = bubble(main_q.pc);
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the downstream side moves.
                    if (out_ready) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = bubble(main_q.pc);
                end
            endcase
        end
        in_ready_d = state_accepts(state_d);
    end

    // State, entries and registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_q     <= bubble(RESET_PC);
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_pc      = main_q.pc;
    assign out_instr   = main_q.instr;
    assign out_exccode = main_q.exccode;
    assign out_bd      = main_q.bd;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    assign stall_inc = out_valid & ~out_ready;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (req),
        .count   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
